// File: rtl/alu_s1.sv
// Execute-stage ALU: registered result/zero flag from pre_alu operands; shifts iterate SHIFT_STEP bits per cycle.
// Latency: 1 cycle for non-shift ops and zero-amount shifts; ceil(n/SHIFT_STEP) extra cycles for an n-bit shift.
// Backpressure: stall_req is held high for the whole multi-cycle shift; upstream freezes and holds its inputs.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   clk_enable              pipeline advance; only matters in IDLE (accept / out_valid update)
//   in_valid, alu_op        request strobe and 4-bit op code
//   pre_alu_a, pre_alu_b    operands; shift amount is pre_alu_b[4:0]
//   result, result_zero     registered result and (result == 0)
//   out_valid               result holds a newly completed op
//   stall_req               high while a shift is iterating
module alu_s1 #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_enable,
  input  logic            in_valid,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] pre_alu_a,
  input  logic [XLEN-1:0] pre_alu_b,
  output logic [XLEN-1:0] result,
  output logic            result_zero,
  output logic            out_valid,
  output logic            stall_req
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SLT    = 4'd3;
  localparam logic [3:0] OP_SLTU   = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_PASS_A = 4'd10;
  localparam logic [3:0] OP_PASS_B = 4'd11;
  localparam logic [3:0] OP_EQ     = 4'd12;
  localparam logic [3:0] OP_NE     = 4'd13;
  localparam logic [3:0] OP_GE     = 4'd14;
  localparam logic [3:0] OP_GEU    = 4'd15;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;
  logic            stall_q, stall_d;

  logic [4:0]      shamt;
  logic            is_shift_op;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      step_amt;
  logic [XLEN-1:0] acc_shifted;
  logic            shift_last;

  assign shamt       = pre_alu_b[4:0];
  assign is_shift_op = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign lt_s        = $signed(pre_alu_a) < $signed(pre_alu_b);
  assign lt_u        = pre_alu_a < pre_alu_b;
  assign eq          = pre_alu_a == pre_alu_b;

  // Single-cycle datapath. Shift ops only reach this path with a zero
  // amount, where the result is simply operand A.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:    alu_res = pre_alu_a + pre_alu_b;
      OP_SUB:    alu_res = pre_alu_a - pre_alu_b;
      OP_SLL,
      OP_SRL,
      OP_SRA:    alu_res = pre_alu_a;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:    alu_res = pre_alu_a ^ pre_alu_b;
      OP_OR:     alu_res = pre_alu_a | pre_alu_b;
      OP_AND:    alu_res = pre_alu_a & pre_alu_b;
      OP_PASS_A: alu_res = pre_alu_a;
      OP_PASS_B: alu_res = pre_alu_b;
      OP_EQ:     alu_res = {{(XLEN-1){1'b0}}, eq};
      OP_NE:     alu_res = {{(XLEN-1){1'b0}}, ~eq};
      OP_GE:     alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_GEU:    alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
      default:   alu_res = '0;
    endcase
  end

  // Iterative shifter: the final step may be shorter than SHIFT_STEP so the
  // total always equals the requested amount.
  always_comb begin
    step_amt    = (cnt_q < STEP) ? cnt_q : STEP;
    acc_shifted = acc_q >> step_amt;
    if (op_q == OP_SLL) begin
      acc_shifted = acc_q << step_amt;
    end else if (op_q == OP_SRA) begin
      acc_shifted = $unsigned($signed(acc_q) >>> step_amt);
    end
    shift_last  = (cnt_q == step_amt);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    stall_d     = stall_q;

    case (state_q)
      IDLE: begin
        if (clk_enable) begin
          if (!in_valid) begin
            out_valid_d = 1'b0;
          end else if (is_shift_op && (shamt != 5'd0)) begin
            acc_d       = pre_alu_a;
            cnt_d       = shamt;
            op_d        = alu_op;
            out_valid_d = 1'b0;
            stall_d     = 1'b1;
            state_d     = SHIFT;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        // Runs regardless of clk_enable/in_valid: the operands were captured
        // at acceptance and upstream is frozen by stall_req.
        acc_d = acc_shifted;
        cnt_d = cnt_q - step_amt;
        if (shift_last) begin
          result_d    = acc_shifted;
          zero_d      = (acc_shifted == '0);
          out_valid_d = 1'b1;
          stall_d     = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign result      = result_q;
  assign result_zero = zero_q;
  assign out_valid   = out_valid_q;
  assign stall_req   = stall_q;

endmodule

// File: tb/tb_alu_s1.sv
// Directed bench for alu_s1: two instances (SHIFT_STEP 1 and 4) with a
// queue-based scoreboard; a monitor pops an expected result each time an
// instance presents a newly completed op.
module tb_alu_s1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLL = 4'd2,   OP_SLT = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4, OP_XOR = 4'd5,  OP_SRL = 4'd6,   OP_SRA = 4'd7;
  localparam logic [3:0] OP_OR = 4'd8,   OP_AND = 4'd9,  OP_PASSA = 4'd10, OP_PASSB = 4'd11;
  localparam logic [3:0] OP_EQ = 4'd12,  OP_NE = 4'd13,  OP_GE = 4'd14,   OP_GEU = 4'd15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        ce    [2];
  logic        iv    [2];
  logic [3:0]  op    [2];
  logic [31:0] a     [2];
  logic [31:0] b     [2];
  logic [31:0] res   [2];
  logic        rz    [2];
  logic        ov    [2];
  logic        st    [2];

  alu_s1 #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .clk_enable(ce[0]), .in_valid(iv[0]), .alu_op(op[0]),
    .pre_alu_a(a[0]), .pre_alu_b(b[0]), .result(res[0]), .result_zero(rz[0]),
    .out_valid(ov[0]), .stall_req(st[0])
  );

  alu_s1 #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .clk_enable(ce[1]), .in_valid(iv[1]), .alu_op(op[1]),
    .pre_alu_a(a[1]), .pre_alu_b(b[1]), .result(res[1]), .result_zero(rz[1]),
    .out_valid(ov[1]), .stall_req(st[1])
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        prev_ov  [2];
  logic        prev_acc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a new output is out_valid rising, or out_valid staying high
  // across an edge at which the instance accepted a request.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        have;
    for (int d = 0; d < 2; d++) begin
      if (ov[d] === 1'b1 && (prev_ov[d] !== 1'b1 || prev_acc[d] === 1'b1)) begin
        have = 1'b0;
        e    = '0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front(); have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front(); have = 1'b1;
        end
        if (!have) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output dut%0d: got result 0x%08h, no result expected", d, res[d]);
        end else begin
          check($sformatf("result_dut%0d", d), res[d], e);
          check($sformatf("result_zero_dut%0d", d), {31'b0, rz[d]}, {31'b0, (e == 32'h0)});
        end
      end
      prev_ov[d]  = ov[d];
      prev_acc[d] = rst_n[d] && ce[d] && iv[d] && !st[d];
    end
  end

  // Present a request (called just after a posedge) and hold it until the
  // instance is idle at an edge; 'waited' counts the edges spent.
  task automatic issue(input int d, input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ex, input bit push, output int waited);
    bit accepted;
    accepted = 1'b0;
    waited   = 0;
    ce[d] = 1'b1; iv[d] = 1'b1; op[d] = o; a[d] = av; b[d] = bv;
    if (push) begin
      if (d == 0) q0.push_back(ex);
      else        q1.push_back(ex);
    end
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (st[d] === 1'b0) accepted = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d: request not accepted in 200 cycles, expected acceptance", d);
    end
    iv[d] = 1'b0;
  endtask

  task automatic stall_len(input int d, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (st[d] !== 1'b1) done = 1'b1;
      else                n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int d, input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ex, input int exp_stall, input string name);
    int w, n;
    issue(d, o, av, bv, ex, 1'b1, w);
    stall_len(d, n);
    check({name, "_stall_cycles"}, n, exp_stall);
  endtask

  initial begin
    int w;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; ce[d] = 1'b0; iv[d] = 1'b0; op[d] = '0; a[d] = '0; b[d] = '0;
      prev_ov[d] = 1'b0; prev_acc[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_result_dut%0d", d), res[d], 32'h0);
      check($sformatf("reset_zero_dut%0d", d), {31'b0, rz[d]}, 32'd1);
      check($sformatf("reset_out_valid_dut%0d", d), {31'b0, ov[d]}, 32'd0);
      check($sformatf("reset_stall_dut%0d", d), {31'b0, st[d]}, 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle ops on the SHIFT_STEP=1 instance
    run(0, OP_ADD,   32'hFFFF_FFFF, 32'h1,         32'h0,         0, "add_wrap");
    run(0, OP_SUB,   32'h5,         32'h7,         32'hFFFF_FFFE, 0, "sub_neg");
    run(0, OP_SLT,   32'hFFFF_FFFF, 32'h1,         32'h1,         0, "slt");
    run(0, OP_SLTU,  32'hFFFF_FFFF, 32'h1,         32'h0,         0, "sltu");
    run(0, OP_GEU,   32'hFFFF_FFFF, 32'h1,         32'h1,         0, "geu");
    run(0, OP_GE,    32'hFFFF_FFFF, 32'h1,         32'h0,         0, "ge");
    run(0, OP_EQ,    32'h1234,      32'h1234,      32'h1,         0, "eq");
    run(0, OP_NE,    32'h1234,      32'h1234,      32'h0,         0, "ne");
    run(0, OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, "xor");
    run(0, OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, "or");
    run(0, OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, "and");
    run(0, OP_PASSB, 32'h1111_1111, 32'hBEEF_0001, 32'hBEEF_0001, 0, "pass_b");

    // Shifts with SHIFT_STEP=1
    run(0, OP_SRA,   32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 31, "sra31");
    run(0, OP_SRL,   32'h1234_5678, 32'h0,         32'h1234_5678, 0,  "srl0");
    run(0, OP_SRL,   32'hF000_0000, 32'h24,        32'h0F00_0000, 4,  "srl4_upper_ignored");

    // clk_enable low in IDLE: request held off, outputs frozen
    issue(0, OP_PASSA, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b1, w);
    ce[0] = 1'b0; iv[0] = 1'b1; op[0] = OP_ADD; a[0] = 32'd2; b[0] = 32'd3;
    repeat (3) begin
      @(negedge clk);
      check("ce0_hold_result", res[0], 32'hCAFE_F00D);
      check("ce0_hold_out_valid", {31'b0, ov[0]}, 32'd1);
    end
    @(posedge clk);
    #1;
    issue(0, OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1, w);

    // in_valid low with clk_enable high: out_valid drops, result holds
    @(posedge clk);
    @(negedge clk);
    check("idle_out_valid_drop", {31'b0, ov[0]}, 32'd0);
    check("idle_result_hold", res[0], 32'd5);
    @(posedge clk);
    #1;

    // Back-to-back: ADD presented during the shift, taken at first IDLE edge
    issue(0, OP_SLL, 32'd3, 32'd3, 32'h18, 1'b1, w);
    issue(0, OP_ADD, 32'd10, 32'd20, 32'd30, 1'b1, w);
    check("b2b_add_accept_edges", w, 4);
    @(posedge clk);
    #1;

    // Reset during the third SHIFT cycle discards the shift
    issue(0, OP_SRL, 32'hF000_0000, 32'd16, 32'h0, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("midshift_rst_stall", {31'b0, st[0]}, 32'd0);
    check("midshift_rst_result", res[0], 32'h0);
    check("midshift_rst_zero", {31'b0, rz[0]}, 32'd1);
    check("midshift_rst_out_valid", {31'b0, ov[0]}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || st[0] !== 1'b0) seen = 1'b1;
    end
    check("midshift_rst_no_completion", {31'b0, seen}, 32'd0);
    @(posedge clk);
    #1;

    // SHIFT_STEP=4 instance
    run(1, OP_SLL, 32'h1,         32'h25,  32'h20,        2, "step4_sll5");
    run(1, OP_SRA, 32'h8000_0000, 32'd31,  32'hFFFF_FFFF, 8, "step4_sra31");
    run(1, OP_SRL, 32'hFFFF_0000, 32'd16,  32'h0000_FFFF, 4, "step4_srl16");
    run(1, OP_SLL, 32'hABCD_1234, 32'd3,   32'h5E68_91A0, 1, "step4_sll3");

    repeat (5) @(posedge clk);
    check("dut0_scoreboard_drained", q0.size(), 32'd0);
    check("dut1_scoreboard_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
